// File: rtl/miriscv_mem_pkg.sv
// Shared types for the miriscv RAM arbiter: port identifiers, lock FSM states
// and the request bundle that every requester presents to the arbiter.
package miriscv_mem_pkg;

  typedef enum logic [1:0] {
    PORT_INSTR = 2'd0,
    PORT_DATA  = 2'd1,
    PORT_LOAD  = 2'd2
  } port_e;

  typedef enum logic {
    ARB_RUN,
    ARB_LOCKED
  } arb_state_e;

  // Wide enough for any supported ADDR_W; narrower addresses are zero-extended.
  localparam int unsigned REQ_ADDR_W = 64;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [3:0]            be;
    logic [REQ_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
  } mem_req_t;

  function automatic mem_req_t pack_req(
    input logic                  req,
    input logic                  we,
    input logic [3:0]            be,
    input logic [REQ_ADDR_W-1:0] addr,
    input logic [31:0]           wdata
  );
    mem_req_t r;
    r.req   = req;
    r.we    = we;
    r.be    = be;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

endpackage

// File: rtl/miriscv_rr_arb2.sv
// Two-input round-robin arbiter between core instruction fetch and data port.
// The port granted last loses the next conflict; a lone request always wins.
module miriscv_rr_arb2
  import miriscv_mem_pkg::*;
(
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic i_req_i,
  input  logic d_req_i,
  output logic i_gnt_o,
  output logic d_gnt_o
);

  // 0: instruction port was granted last, 1: data port was granted last
  logic r_rr_last_data;
  logic w_i_gnt;
  logic w_d_gnt;

  always_comb begin
    w_i_gnt = en_i & i_req_i & (~d_req_i |  r_rr_last_data);
    w_d_gnt = en_i & d_req_i & (~i_req_i | ~r_rr_last_data);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rr_last_data <= 1'b0;
    end else if (w_i_gnt) begin
      r_rr_last_data <= 1'b0;
    end else if (w_d_gnt) begin
      r_rr_last_data <= 1'b1;
    end
  end

  assign i_gnt_o = w_i_gnt;
  assign d_gnt_o = w_d_gnt;

endmodule

// File: rtl/miriscv_ram_arbiter.sv
// Arbitrates the single-port program/data RAM between core fetch, core LSU and
// an external loader, with a loader lock and one-cycle response routing.
module miriscv_ram_arbiter
  import miriscv_mem_pkg::*;
#(
  parameter int unsigned RAM_SIZE = 512,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,

  input  logic                        i_req_i,
  input  logic                        i_we_i,
  input  logic [3:0]                  i_be_i,
  input  logic [ADDR_W-1:0]           i_addr_i,
  input  logic [31:0]                 i_wdata_i,
  output logic                        i_gnt_o,
  output logic                        i_rvalid_o,
  output logic                        i_err_o,
  output logic [31:0]                 i_rdata_o,

  input  logic                        d_req_i,
  input  logic                        d_we_i,
  input  logic [3:0]                  d_be_i,
  input  logic [ADDR_W-1:0]           d_addr_i,
  input  logic [31:0]                 d_wdata_i,
  output logic                        d_gnt_o,
  output logic                        d_rvalid_o,
  output logic                        d_err_o,
  output logic [31:0]                 d_rdata_o,

  input  logic                        l_req_i,
  input  logic                        l_we_i,
  input  logic [3:0]                  l_be_i,
  input  logic [ADDR_W-1:0]           l_addr_i,
  input  logic [31:0]                 l_wdata_i,
  output logic                        l_gnt_o,
  output logic                        l_rvalid_o,
  output logic                        l_err_o,
  output logic [31:0]                 l_rdata_o,

  input  logic                        l_lock_i,
  output logic                        locked_o,

  output logic                        ram_req_o,
  output logic                        ram_we_o,
  output logic [3:0]                  ram_be_o,
  output logic [$clog2(RAM_SIZE)-1:0] ram_addr_o,
  output logic [31:0]                 ram_wdata_o,
  input  logic [31:0]                 ram_rdata_i
);

  localparam int unsigned AW = $clog2(RAM_SIZE);

  arb_state_e r_state;
  arb_state_e w_state_nxt;

  mem_req_t   w_i_req;
  mem_req_t   w_d_req;
  mem_req_t   w_l_req;
  mem_req_t   w_win;
  port_e      w_win_port;

  logic       w_core_en;
  logic       w_i_gnt;
  logic       w_d_gnt;
  logic       w_l_gnt;
  logic       w_in_range;
  logic       w_unused;

  logic       r_resp_valid;
  port_e      r_resp_owner;
  logic       r_resp_err;
  logic [31:0] w_resp_rdata;

  // Lock FSM
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ARB_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_RUN:    if (l_lock_i)  w_state_nxt = ARB_LOCKED;
      ARB_LOCKED: if (!l_lock_i) w_state_nxt = ARB_RUN;
      default:    w_state_nxt = ARB_RUN;
    endcase
  end

  always_comb begin
    locked_o = (r_state == ARB_LOCKED);
  end

  // Grants are also gated by reset so every output reads 0 while it is held.
  always_comb begin
    w_i_req   = pack_req(i_req_i, 1'b0,   i_be_i, REQ_ADDR_W'(i_addr_i), i_wdata_i);
    w_d_req   = pack_req(d_req_i, d_we_i, d_be_i, REQ_ADDR_W'(d_addr_i), d_wdata_i);
    w_l_req   = pack_req(l_req_i, l_we_i, l_be_i, REQ_ADDR_W'(l_addr_i), l_wdata_i);
    w_l_gnt   = rst_n_i & w_l_req.req;
    w_core_en = rst_n_i & ~w_l_req.req & (r_state == ARB_RUN);
  end

  miriscv_rr_arb2 u_rr_arb2 (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (w_core_en),
    .i_req_i (w_i_req.req),
    .d_req_i (w_d_req.req),
    .i_gnt_o (w_i_gnt),
    .d_gnt_o (w_d_gnt)
  );

  always_comb begin
    w_win      = '0;
    w_win_port = PORT_INSTR;
    if (w_l_gnt) begin
      w_win      = w_l_req;
      w_win_port = PORT_LOAD;
    end else if (w_d_gnt) begin
      w_win      = w_d_req;
      w_win_port = PORT_DATA;
    end else if (w_i_gnt) begin
      w_win      = w_i_req;
      w_win_port = PORT_INSTR;
    end
  end

  // RAM_SIZE is a power of two, so word < RAM_SIZE means all higher word bits are 0.
  always_comb begin
    w_in_range  = (w_win.addr[REQ_ADDR_W-1:AW+2] == '0);
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (w_win.req && w_in_range) begin
      ram_req_o   = 1'b1;
      ram_we_o    = w_win.we;
      ram_be_o    = w_win.be;
      ram_addr_o  = w_win.addr[AW+1:2];
      ram_wdata_o = w_win.wdata;
    end
  end

  assign w_unused = ^{i_we_i, w_win.addr[1:0]};

  always_comb begin
    i_gnt_o = w_i_gnt;
    d_gnt_o = w_d_gnt;
    l_gnt_o = w_l_gnt;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_resp_valid <= 1'b0;
      r_resp_owner <= PORT_INSTR;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= w_win.req;
      r_resp_owner <= w_win_port;
      r_resp_err   <= w_win.req & ~w_in_range;
    end
  end

  always_comb begin
    w_resp_rdata = r_resp_err ? '0 : ram_rdata_i;
    i_rvalid_o   = r_resp_valid && (r_resp_owner == PORT_INSTR);
    d_rvalid_o   = r_resp_valid && (r_resp_owner == PORT_DATA);
    l_rvalid_o   = r_resp_valid && (r_resp_owner == PORT_LOAD);
    i_err_o      = i_rvalid_o & r_resp_err;
    d_err_o      = d_rvalid_o & r_resp_err;
    l_err_o      = l_rvalid_o & r_resp_err;
    i_rdata_o    = i_rvalid_o ? w_resp_rdata : '0;
    d_rdata_o    = d_rvalid_o ? w_resp_rdata : '0;
    l_rdata_o    = l_rvalid_o ? w_resp_rdata : '0;
  end

endmodule

// File: tb/tb_miriscv_ram_arbiter.sv
// Bench for miriscv_ram_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_miriscv_ram_arbiter;

  localparam int unsigned RAM_SIZE = 512;
  localparam int unsigned ADDR_W   = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req[3];
  logic        we[3];
  logic [3:0]  be[3];
  logic [31:0] addr[3];
  logic [31:0] wdata[3];
  logic        lock;

  logic        gnt[3];
  logic        rvalid[3];
  logic        err[3];
  logic [31:0] rdata[3];
  logic        locked;
  logic        ram_req, ram_we;
  logic [3:0]  ram_be;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;

  logic [31:0] ram_mem[RAM_SIZE];
  logic [31:0] gold_mem[RAM_SIZE];

  int n_vec = 0;
  int n_err = 0;

  // Model state: lock, last core grantee, and the response owed next cycle
  bit          m_locked;
  bit          m_last_instr;
  bit          m_pend;
  int          m_pend_port;
  bit          m_pend_err;
  bit          m_pend_we;
  logic [31:0] m_pend_rd;

  always #5 clk = ~clk;

  miriscv_ram_arbiter #(.RAM_SIZE(RAM_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .i_req_i(req[0]), .i_we_i(we[0]), .i_be_i(be[0]), .i_addr_i(addr[0]), .i_wdata_i(wdata[0]),
    .i_gnt_o(gnt[0]), .i_rvalid_o(rvalid[0]), .i_err_o(err[0]), .i_rdata_o(rdata[0]),
    .d_req_i(req[1]), .d_we_i(we[1]), .d_be_i(be[1]), .d_addr_i(addr[1]), .d_wdata_i(wdata[1]),
    .d_gnt_o(gnt[1]), .d_rvalid_o(rvalid[1]), .d_err_o(err[1]), .d_rdata_o(rdata[1]),
    .l_req_i(req[2]), .l_we_i(we[2]), .l_be_i(be[2]), .l_addr_i(addr[2]), .l_wdata_i(wdata[2]),
    .l_gnt_o(gnt[2]), .l_rvalid_o(rvalid[2]), .l_err_o(err[2]), .l_rdata_o(rdata[2]),
    .l_lock_i(lock), .locked_o(locked),
    .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  // Single-port RAM with read-first, one-cycle read latency
  always @(posedge clk) begin
    if (ram_req) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    for (int p = 0; p < 3; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; be[p] = '0; addr[p] = '0; wdata[p] = '0;
    end
  endtask

  task automatic set_port(input int p, input bit r, input bit w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d);
    req[p] = r; we[p] = w; be[p] = b; addr[p] = a; wdata[p] = d;
  endtask

  // Called at posedge+1 with inputs set; checks mid-cycle, advances the model,
  // and returns at the next posedge+1.
  task automatic cycle();
    int          g;
    int unsigned word;
    bit          inr;
    bit          ev;
    logic [31:0] nv;
    #5;
    if (!rst_n) begin
      m_locked = 0; m_last_instr = 1; m_pend = 0;
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("rst_gnt%0d", p), gnt[p], 0);
        chk($sformatf("rst_rvalid%0d", p), rvalid[p], 0);
        chk($sformatf("rst_err%0d", p), err[p], 0);
        chk($sformatf("rst_rdata%0d", p), rdata[p], 0);
      end
      chk("rst_locked", locked, 0);
      chk("rst_ram_req", ram_req, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_be", ram_be, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
    end else begin
      for (int p = 0; p < 3; p++) begin
        ev = m_pend && (m_pend_port == p);
        chk($sformatf("rvalid%0d", p), rvalid[p], ev);
        chk($sformatf("err%0d", p), err[p], ev && m_pend_err);
        if (!(ev && m_pend_we && !m_pend_err))
          chk($sformatf("rdata%0d", p), rdata[p], (ev && !m_pend_err) ? m_pend_rd : 32'h0);
      end
      chk("locked", locked, m_locked);

      g = -1;
      if (req[2]) g = 2;
      else if (!m_locked) begin
        if (req[0] && req[1]) g = m_last_instr ? 1 : 0;
        else if (req[0]) g = 0;
        else if (req[1]) g = 1;
      end
      for (int p = 0; p < 3; p++) chk($sformatf("gnt%0d", p), gnt[p], g == p);

      word = 0;
      if (g >= 0) word = addr[g] >> 2;
      inr = (g >= 0) && (word < RAM_SIZE);
      chk("ram_req", ram_req, inr);
      if (inr) begin
        chk("ram_addr", ram_addr, word);
        chk("ram_we", ram_we, (g != 0) && we[g]);
        chk("ram_be", ram_be, be[g]);
        chk("ram_wdata", ram_wdata, wdata[g]);
      end

      m_pend      = (g >= 0);
      m_pend_port = g;
      m_pend_err  = !inr;
      m_pend_we   = (g != 0) && (g >= 0) && we[g];
      m_pend_rd   = inr ? gold_mem[word] : 32'h0;
      if (inr && m_pend_we) begin
        nv = gold_mem[word];
        for (int b = 0; b < 4; b++)
          if (be[g][b]) nv[8*b +: 8] = wdata[g][8*b +: 8];
        gold_mem[word] = nv;
      end
      if (g == 0) m_last_instr = 1;
      if (g == 1) m_last_instr = 0;
      m_locked = lock;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < RAM_SIZE; i++) begin
      v = $urandom;
      ram_mem[i]  = v;
      gold_mem[i] = v;
    end
    idle();
    lock  = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    // Reset with every port requesting: nothing may leak out
    set_port(0, 1, 0, 4'hF, 32'h10, 32'h0);
    set_port(1, 1, 0, 4'hF, 32'h20, 32'h0);
    set_port(2, 1, 1, 4'hF, 32'h30, 32'h55);
    cycle();
    idle();
    rst_n = 1'b1;

    // Lone fetch of word 4
    set_port(0, 1, 0, 4'hF, 32'h0000_0010, 32'h0);
    cycle();
    idle();
    chk("fetch_rdata", rdata[0], gold_mem[4]);
    cycle();

    // i/d conflict from reset: D, I, D, I
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_port(0, 1, 0, 4'hF, 32'h40 + 4*k, 32'h0);
      set_port(1, 1, 0, 4'hF, 32'h80 + 4*k, 32'h0);
      cycle();
    end
    idle();
    cycle();

    // Loader lock: write 0x13 to word 0 while fetch of word 0 waits
    lock = 1'b1;
    cycle();
    set_port(0, 1, 0, 4'hF, 32'h0, 32'h0);
    set_port(2, 1, 1, 4'hF, 32'h0, 32'h0000_0013);
    cycle();
    req[2] = 1'b0;
    cycle();
    chk("fetch_held", gnt[0], 0);
    lock = 1'b0;
    cycle();
    cycle();
    req[0] = 1'b0;
    chk("fetch_after_unlock", rdata[0], 32'h0000_0013);
    cycle();

    // Out-of-range data read
    set_port(1, 1, 0, 4'hF, 32'h0000_0800, 32'h0);
    cycle();
    idle();
    chk("oor_err", err[1], 1);
    chk("oor_rdata", rdata[1], 0);
    cycle();

    // Byte write merge
    set_port(2, 1, 1, 4'hF, 32'h14, 32'h1122_3344);
    cycle();
    idle();
    set_port(1, 1, 1, 4'b0010, 32'h14, 32'hAABB_CCDD);
    cycle();
    set_port(1, 1, 0, 4'hF, 32'h16, 32'h0);
    cycle();
    idle();
    chk("byte_merge", rdata[1], 32'h1122_CC44);
    cycle();

    // Reset in the cycle after a data grant discards its response
    set_port(1, 1, 0, 4'hF, 32'h24, 32'h0);
    cycle();
    idle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    set_port(0, 1, 0, 4'hF, 32'h28, 32'h0);
    set_port(1, 1, 0, 4'hF, 32'h2C, 32'h0);
    cycle();
    idle();
    cycle();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 3; p++) begin
        int unsigned w;
        w = ($urandom_range(0, 7) == 0) ? RAM_SIZE + $urandom_range(0, 5000) : $urandom_range(0, RAM_SIZE - 1);
        req[p]   = (p == 2) ? ($urandom_range(0, 3) == 0) : $urandom_range(0, 1);
        we[p]    = $urandom_range(0, 1);
        be[p]    = 4'($urandom);
        addr[p]  = (w << 2) | ($urandom & 32'h3);
        wdata[p] = $urandom;
      end
      if ($urandom_range(0, 7) == 0) lock = ~lock;
      rst_n = ($urandom_range(0, 99) != 0);
      cycle();
    end
    rst_n = 1'b1;
    idle();
    lock = 1'b0;
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
